// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : CPU, external-requester and memory-port signals of the arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_o_data;
  logic        cpu_we;
  logic        cpu_locked;
  logic        ext_req;
  logic [15:0] ext_address;
  logic        ext_grant;
  logic [15:0] mem_address;
  logic [7:0]  mem_o_data;
  logic        mem_we;
  logic [7:0]  mem_i_data;

  modport master (
    input  cpu_address, cpu_o_data, cpu_we, ext_req, ext_address, mem_i_data,
    output cpu_locked, ext_grant, mem_address, mem_o_data, mem_we
  );

  modport slave (
    output cpu_address, cpu_o_data, cpu_we, ext_req, ext_address, mem_i_data,
    input  cpu_locked, ext_grant, mem_address, mem_o_data, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one synchronous memory port between CPU, OAM DMA and an
//               external read requester. Optional MEM_BUS_ARBITER_DMA_ALIGN_EN
//               adds a DMA_ALN cycle before the first DMA read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004
) (
  input  wire               clock,
  input  wire               resetn,
  input  wire               pll_locked,
  mem_bus_arbiter_if.master bus
);

  localparam logic [2:0] c_st_cpu    = 3'd0;
  localparam logic [2:0] c_st_rfch   = 3'd1;
  localparam logic [2:0] c_st_ext    = 3'd2;
  localparam logic [2:0] c_st_dma_rd = 3'd3;
  localparam logic [2:0] c_st_dma_wr = 3'd4;
`ifdef MEM_BUS_ARBITER_DMA_ALIGN_EN
  localparam logic [2:0] c_st_dma_aln = 3'd5;
`endif

  logic [2:0]  r_state;
  logic        r_ret_dma;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;

  logic        w_trigger;
  logic [15:0] w_mem_address;
  logic [7:0]  w_mem_o_data;
  logic        w_mem_we;

  assign w_trigger = bus.cpu_we && (bus.cpu_address == DMA_REG);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= c_st_rfch;
      r_ret_dma <= 1'b0;
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
    end else if (pll_locked) begin
      case (r_state)
        c_st_cpu: begin
          if (w_trigger) begin
            r_page  <= bus.cpu_o_data;
            r_idx   <= 8'h00;
`ifdef MEM_BUS_ARBITER_DMA_ALIGN_EN
            r_state <= c_st_dma_aln;
`else
            r_state <= c_st_dma_rd;
`endif
          end else if (bus.ext_req) begin
            r_state   <= c_st_ext;
            r_ret_dma <= 1'b0;
          end
        end
        c_st_rfch:   r_state <= c_st_cpu;
        c_st_ext:    r_state <= r_ret_dma ? c_st_dma_rd : c_st_rfch;
        c_st_dma_rd: r_state <= c_st_dma_wr;
        c_st_dma_wr: begin
          r_idx <= r_idx + 8'd1;
          // A steal after the final byte must not resume the finished DMA.
          if (bus.ext_req) begin
            r_state   <= c_st_ext;
            r_ret_dma <= (r_idx != 8'hFF);
          end else begin
            r_state   <= (r_idx == 8'hFF) ? c_st_rfch : c_st_dma_rd;
          end
        end
`ifdef MEM_BUS_ARBITER_DMA_ALIGN_EN
        c_st_dma_aln: r_state <= c_st_dma_rd;
`endif
        default:     r_state <= c_st_rfch;
      endcase
    end
  end

  always_comb begin
    w_mem_address = bus.cpu_address;
    w_mem_o_data  = bus.cpu_o_data;
    w_mem_we      = 1'b0;
    case (r_state)
      c_st_cpu:    w_mem_we = bus.cpu_we;
      c_st_ext:    w_mem_address = bus.ext_address;
      c_st_dma_rd: w_mem_address = {r_page, r_idx};
      c_st_dma_wr: begin
        w_mem_address = OAM_DATA;
        w_mem_o_data  = bus.mem_i_data;
        w_mem_we      = 1'b1;
      end
`ifdef MEM_BUS_ARBITER_DMA_ALIGN_EN
      c_st_dma_aln: w_mem_address = {r_page, 8'h00};
`endif
      default:     ;
    endcase
  end

  assign bus.mem_address = w_mem_address;
  assign bus.mem_o_data  = w_mem_o_data;
  assign bus.mem_we      = w_mem_we & pll_locked;
  assign bus.cpu_locked  = pll_locked & (r_state == c_st_cpu);
  assign bus.ext_grant   = pll_locked & (r_state == c_st_ext);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam logic [15:0] c_dma_reg  = 16'h4014;
  localparam logic [15:0] c_oam_data = 16'h2004;
  localparam logic [15:0] c_ext_addr = 16'h1234;
  localparam logic [7:0]  c_ext_byte = 8'h5C;
`ifdef MEM_BUS_ARBITER_DMA_ALIGN_EN
  localparam int c_aln = 1;
`else
  localparam int c_aln = 0;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic pll_locked = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   oam_wr = 0;
  bit   loaded = 1'b0;
  logic [7:0] mem [0:65535];

  mem_bus_arbiter_if bus();

  mem_bus_arbiter dut (
    .clock      (clock),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // Synchronous memory: read data appears one cycle after its address.
  always @(posedge clock) begin
    if (!loaded) begin
      for (int a = 0; a < 65536; a++) mem[a] <= 8'h00;
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] <= i[7:0] ^ 8'hA5;
      mem[c_ext_addr] <= c_ext_byte;
      loaded <= 1'b1;
    end else begin
      if (bus.mem_we) begin
        mem[bus.mem_address] <= bus.mem_o_data;
        if (bus.mem_address == c_oam_data) oam_wr <= oam_wr + 1;
      end
      bus.mem_i_data <= mem[bus.mem_address];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one full DMA of page 8'h02 from a CPU-state negedge, optionally with
  // ext_req held high from the trigger cycle onward.
  task automatic dma_seq(input bit steal);
    int stall = 0;
    int wr0   = oam_wr;
    bus.cpu_address = c_dma_reg;
    bus.cpu_o_data  = 8'h02;
    bus.cpu_we      = 1'b1;
    bus.ext_req     = steal;
    bus.ext_address = c_ext_addr;
    #1;
    chk("trig_locked", {15'd0, bus.cpu_locked}, 16'd1);
    chk("trig_we", {15'd0, bus.mem_we}, 16'd1);
    chk("trig_addr", bus.mem_address, c_dma_reg);
    @(negedge clock);
    bus.cpu_we = 1'b0;
`ifdef MEM_BUS_ARBITER_DMA_ALIGN_EN
    chk("aln_addr", bus.mem_address, 16'h0200);
    chk("aln_grant", {15'd0, bus.ext_grant}, 16'd0);
    if (!bus.cpu_locked) stall++;
    @(negedge clock);
`endif
    for (int i = 0; i < 256; i++) begin
      chk("rd_addr", bus.mem_address, {8'h02, i[7:0]});
      chk("rd_we", {15'd0, bus.mem_we}, 16'd0);
      chk("rd_grant", {15'd0, bus.ext_grant}, 16'd0);
      if (steal && i > 0) chk("ext_data", {8'd0, bus.mem_i_data}, {8'd0, c_ext_byte});
      if (!bus.cpu_locked) stall++;
      @(negedge clock);
      chk("wr_addr", bus.mem_address, c_oam_data);
      chk("wr_we", {15'd0, bus.mem_we}, 16'd1);
      chk("wr_data", {8'd0, bus.mem_o_data}, {8'd0, i[7:0] ^ 8'hA5});
      if (!bus.cpu_locked) stall++;
      @(negedge clock);
      if (steal) begin
        chk("steal_grant", {15'd0, bus.ext_grant}, 16'd1);
        chk("steal_addr", bus.mem_address, c_ext_addr);
        chk("steal_we", {15'd0, bus.mem_we}, 16'd0);
        if (!bus.cpu_locked) stall++;
        if (i == 255) bus.ext_req = 1'b0;
        @(negedge clock);
      end
    end
    chk("rfch_addr", bus.mem_address, c_dma_reg);
    chk("rfch_locked", {15'd0, bus.cpu_locked}, 16'd0);
    chk("rfch_grant", {15'd0, bus.ext_grant}, 16'd0);
    if (!bus.cpu_locked) stall++;
    @(negedge clock);
    chk("dma_end_locked", {15'd0, bus.cpu_locked}, 16'd1);
    chk("dma_stall", stall[15:0], steal ? 16'(769 + c_aln) : 16'(513 + c_aln));
    chk("dma_oam_count", 16'(oam_wr - wr0), 16'd256);
    chk("oam_last", {8'd0, mem[c_oam_data]}, 16'h005A);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    bus.cpu_address = 16'hFFFC;
    bus.cpu_o_data  = 8'h00;
    bus.cpu_we      = 1'b0;
    bus.ext_req     = 1'b0;
    bus.ext_address = 16'h0000;

    // Reset state and the refetch cycle that follows release.
    repeat (3) @(negedge clock);
    chk("rst_locked", {15'd0, bus.cpu_locked}, 16'd0);
    chk("rst_grant", {15'd0, bus.ext_grant}, 16'd0);
    chk("rst_we", {15'd0, bus.mem_we}, 16'd0);
    chk("rst_addr", bus.mem_address, 16'hFFFC);
    resetn = 1'b1;
    #1;
    chk("rel_rfch_locked", {15'd0, bus.cpu_locked}, 16'd0);
    @(negedge clock);
    chk("rel_locked", {15'd0, bus.cpu_locked}, 16'd1);
    chk("rel_addr", bus.mem_address, 16'hFFFC);

    // Plain CPU write then read-back.
    bus.cpu_address = 16'h0300;
    bus.cpu_o_data  = 8'h77;
    bus.cpu_we      = 1'b1;
    #1;
    chk("cpu_we", {15'd0, bus.mem_we}, 16'd1);
    chk("cpu_wdata", {8'd0, bus.mem_o_data}, 16'h0077);
    chk("cpu_waddr", bus.mem_address, 16'h0300);
    @(negedge clock);
    bus.cpu_we = 1'b0;
    chk("cpu_stay_locked", {15'd0, bus.cpu_locked}, 16'd1);
    @(negedge clock);
    chk("cpu_rdata", {8'd0, bus.mem_i_data}, 16'h0077);

    // Single-cycle external steal.
    bus.cpu_address = 16'h8000;
    bus.ext_req     = 1'b1;
    bus.ext_address = c_ext_addr;
    @(negedge clock);
    bus.ext_req = 1'b0;
    chk("ext_grant", {15'd0, bus.ext_grant}, 16'd1);
    chk("ext_addr", bus.mem_address, c_ext_addr);
    chk("ext_we", {15'd0, bus.mem_we}, 16'd0);
    chk("ext_locked", {15'd0, bus.cpu_locked}, 16'd0);
    @(negedge clock);
    chk("ext_rdata", {8'd0, bus.mem_i_data}, {8'd0, c_ext_byte});
    chk("ext_rfch_addr", bus.mem_address, 16'h8000);
    chk("ext_rfch_grant", {15'd0, bus.ext_grant}, 16'd0);
    chk("ext_rfch_locked", {15'd0, bus.cpu_locked}, 16'd0);
    @(negedge clock);
    chk("ext_back_locked", {15'd0, bus.cpu_locked}, 16'd1);

    // Full DMA, then DMA with a simultaneous and persistent ext_req.
    dma_seq(1'b0);
    dma_seq(1'b1);

    // Freeze in DMA_RD at idx 8'h10, then reset in DMA_WR at idx 8'h40.
    bus.cpu_address = c_dma_reg;
    bus.cpu_o_data  = 8'h02;
    bus.cpu_we      = 1'b1;
    @(negedge clock);
    bus.cpu_we = 1'b0;
    repeat (32 + c_aln) @(negedge clock);
    chk("frz_pre_addr", bus.mem_address, 16'h0210);
    pll_locked = 1'b0;
    #1;
    chk("frz_we", {15'd0, bus.mem_we}, 16'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("frz_addr", bus.mem_address, 16'h0210);
      chk("frz_we_hold", {15'd0, bus.mem_we}, 16'd0);
      chk("frz_locked", {15'd0, bus.cpu_locked}, 16'd0);
      chk("frz_grant", {15'd0, bus.ext_grant}, 16'd0);
    end
    pll_locked = 1'b1;
    @(negedge clock);
    chk("resume_addr", bus.mem_address, c_oam_data);
    chk("resume_we", {15'd0, bus.mem_we}, 16'd1);
    chk("resume_data", {8'd0, bus.mem_o_data}, 16'h00B5);
    @(negedge clock);
    chk("resume_next_addr", bus.mem_address, 16'h0211);
    repeat (95) @(negedge clock);
    chk("pre_rst_addr", bus.mem_address, c_oam_data);
    chk("pre_rst_data", {8'd0, bus.mem_o_data}, 16'h00E5);
    resetn = 1'b0;
    #1;
    snap = oam_wr;
    chk("mid_rst_we", {15'd0, bus.mem_we}, 16'd0);
    chk("mid_rst_locked", {15'd0, bus.cpu_locked}, 16'd0);
    chk("mid_rst_addr", bus.mem_address, c_dma_reg);
    bus.cpu_address = 16'hFFFC;
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("post_rst_rfch_addr", bus.mem_address, 16'hFFFC);
    chk("post_rst_rfch_locked", {15'd0, bus.cpu_locked}, 16'd0);
    @(negedge clock);
    chk("post_rst_locked", {15'd0, bus.cpu_locked}, 16'd1);
    repeat (5) @(negedge clock);
    chk("post_rst_no_oam", 16'(oam_wr - snap), 16'd0);
    chk("post_rst_still_locked", {15'd0, bus.cpu_locked}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Owns the single synchronous memory port and shares it between three requesters: the CPU core, an OAM-style DMA engine, and one external read-only requester (video or debug fetch).
- Generates the CPU's `locked` advance enable, so the CPU stalls whenever it does not own the bus.
- Sits between the CPU core and the memory/IO decoder.

Parameters:
- DMA_REG, 16'h4014: CPU write address that triggers DMA; the written byte is the source page.
- OAM_DATA, 16'h2004: destination address for every DMA write.

Ports:
- clock  in  1  system clock, 25 MHz
- resetn  in  1  asynchronous active-low reset
- pll_locked  in  1  global run enable; when 0 the arbiter freezes
- cpu_address  in  16  CPU bus address
- cpu_o_data  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_locked  out  1  CPU may advance this cycle
- ext_req  in  1  external read request, level
- ext_address  in  16  external read address
- ext_grant  out  1  external access owns the bus this cycle
- mem_address  out  16  memory address
- mem_o_data  out  8  memory write data
- mem_we  out  1  memory write enable
- mem_i_data  in  8  memory read data; valid one cycle after its address is presented

Behaviour:
- Memory model: synchronous read. mem_i_data in cycle N+1 reflects mem_address of cycle N. The CPU and the external requester read mem_i_data directly.
- States: CPU, RFCH (refetch), EXT, DMA_RD, DMA_WR.
- Registers: state, ret_dma flag, page[7:0], idx[7:0].
- cpu_locked = pll_locked & (state==CPU).
- ext_grant = pll_locked & (state==EXT).
- Both outputs decode from state only; there is no combinational path from the request inputs.
- Bus mux (combinational):
  - CPU, RFCH: mem_address = cpu_address.
  - CPU only: mem_we = cpu_we, mem_o_data = cpu_o_data.
  - EXT: mem_address = ext_address, mem_we = 0.
  - DMA_RD: mem_address = {page, idx}, mem_we = 0.
  - DMA_WR: mem_address = OAM_DATA, mem_o_data = mem_i_data, mem_we = 1.
  - mem_we is forced to 0 whenever pll_locked = 0.
- Reset:
  - state = RFCH, ret_dma = 0, page = 0, idx = 0.
  - Outputs: cpu_locked = 0, ext_grant = 0, mem_we = 0.
  - RFCH after reset presents the CPU's reset PC, so the first opcode is valid.
  - Reset mid-DMA abandons the transfer.
- Transitions, evaluated only when pll_locked = 1; otherwise all state holds:
  - CPU, with cpu_we & cpu_address==DMA_REG: page <= cpu_o_data, idx <= 0, go to DMA_RD. The trigger write itself still reaches memory. DMA has priority over ext_req.
  - CPU, else if ext_req: go to EXT with ret_dma = 0.
  - CPU, else: stay in CPU.
  - EXT: go to DMA_RD if ret_dma, else RFCH. Exactly one cycle per grant; no back-to-back grants.
  - DMA_RD: always go to DMA_WR. No steal between read and write.
  - DMA_WR: idx <= idx + 1 (8-bit, wraps).
    - If idx==8'hFF: go to EXT (ret_dma = 0) if ext_req, else RFCH.
    - Otherwise: go to EXT (ret_dma = 1) if ext_req, else DMA_RD.
  - RFCH: go to CPU. This is one stall cycle that re-presents cpu_address so the CPU sees valid data.
- DMA length: 256 bytes, 512 bus cycles plus steals. Minimum CPU stall after the trigger is 513 cycles (DMA plus RFCH).
- Freeze: while pll_locked = 0, mem_address holds its current-state value. Reads are idempotent, so a freeze between DMA_RD and DMA_WR loses no data.

Optional Feature:
- Macro: MEM_BUS_ARBITER_DMA_ALIGN_EN.
- Defined: the DMA trigger enters an extra state DMA_ALN before DMA_RD.
  - One cycle with mem_address = {page, 8'h00} and mem_we = 0.
  - Minimum stall becomes 514 cycles.
  - ext_req is not granted during DMA_ALN.
- Undefined: DMA_ALN is absent and the trigger goes straight to DMA_RD.

Test Plan:
- Reset:
  - Stimulus: assert resetn = 0 during DMA_WR with idx = 8'h40, then release.
  - Response: mem_we = 0 and cpu_locked = 0 immediately. After release, one RFCH cycle with mem_address = cpu_address, then cpu_locked = 1. No further $2004 writes.
- DMA:
  - Stimulus: memory preloaded $0200+i = i^8'hA5. CPU writes 8'h02 to $4014.
  - Response: 256 pairs of read $02ii / write $2004 with data ii^A5, in order i = 00..FF. cpu_locked = 0 for 513 cycles after the trigger cycle.
- External steal:
  - Stimulus: ext_req pulsed high for 1 cycle in the CPU state with ext_address = $1234.
  - Response: the next cycle shows ext_grant = 1 and mem_address = $1234, then one RFCH cycle, then cpu_locked = 1. The ext data equals mem[$1234] one cycle after the grant.
- Steal during DMA:
  - Stimulus: ext_req held high through a whole DMA.
  - Response: exactly one EXT after every DMA_WR. Never an EXT between DMA_RD and DMA_WR. 256 correct writes; total stall 768+1 cycles.
- Simultaneous trigger:
  - Stimulus: DMA trigger and ext_req in the same CPU cycle.
  - Response: DMA_RD of $0200 first, then DMA_WR, then the EXT grant.
- Freeze:
  - Stimulus: pll_locked = 0 for 10 cycles while in DMA_RD with idx = 8'h10.
  - Response: mem_we = 0, mem_address = $0210 held, and no locked or grant pulses. On resume, the write of mem[$0210] to $2004 is correct and idx continues from 11.
